// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   ADDRESS_WIDTH / INST_DATA_WIDTH : default PC and instruction widths
//   PC_STEP                         : byte distance between sequential fetches
//   redirect_src_e / pick_redirect  : redirect source selection (rob > decoder > bp)
package if_fetch_unit_pkg;

    localparam int ADDRESS_WIDTH   = 32;
    localparam int INST_DATA_WIDTH = 32;
    localparam int PC_STEP         = 4;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_BP,
        SRC_DECODER,
        SRC_ROB
    } redirect_src_e;

    // The ROB knows the architecturally correct path, so it overrides the
    // decoder, which in turn knows more than the predictor.
    function automatic redirect_src_e pick_redirect(
        input logic rob_en,
        input logic decoder_en,
        input logic bp_en
    );
        if (rob_en)          return SRC_ROB;
        else if (decoder_en) return SRC_DECODER;
        else if (bp_en)      return SRC_BP;
        else                 return SRC_NONE;
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Fetch FIFO holding {pc, instruction} pairs between icache and instruction queue.
//   clk_in, rst_in    : clock, asynchronous active-high reset
//   flush             : synchronous clear of all entries (wins over push)
//   push, push_data   : write one entry at the tail
//   pop               : remove the head entry
//   head_data         : current head entry (meaningful only when !empty)
//   empty, count      : occupancy status
// Push and pop together are legal at any occupancy, including full.
module if_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    assign head_data = mem[rd_ptr];
    assign empty     = (count == '0);

    // NOTE: the storage array is reset so the head outputs read as zero out of
    // reset; a flush only rewinds the pointers and leaves old data in place.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end.
//   clk_in, rst_in, rdy_in           : clock, async active-high reset, global enable
//   if_icache_*/icache_if_*          : pipelined in-order icache request/response
//   if_instqueue_*/instqueue_if_*    : valid/ready delivery of {pc, inst}
//   rob/decoder/bp_if_en_in, *_pc_in : redirect requests, priority rob > decoder > bp
// Keeps the fetch PC, issues up to MAX_OUTSTANDING requests, buffers responses
// in a DEPTH-entry FIFO and discards in-flight responses after a redirect.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = ADDRESS_WIDTH,
    parameter int                    INST_WIDTH      = INST_DATA_WIDTH,
    parameter int                    DEPTH           = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    output logic                  if_icache_req_valid_out,
    input  logic                  icache_if_req_ready_in,
    output logic [ADDR_WIDTH-1:0] if_icache_addr_out,
    input  logic                  icache_if_resp_valid_in,
    input  logic [INST_WIDTH-1:0] icache_if_inst_in,
    output logic                  if_instqueue_valid_out,
    input  logic                  instqueue_if_ready_in,
    output logic [INST_WIDTH-1:0] if_instqueue_inst_out,
    output logic [ADDR_WIDTH-1:0] if_instqueue_pc_out,
    input  logic                  rob_if_en_in,
    input  logic [ADDR_WIDTH-1:0] rob_if_pc_in,
    input  logic                  decoder_if_en_in,
    input  logic [ADDR_WIDTH-1:0] decoder_if_pc_in,
    input  logic                  bp_if_en_in,
    input  logic [ADDR_WIDTH-1:0] bp_if_pc_in
);

    localparam int                    CW      = $clog2(DEPTH+1);
    localparam int                    EW      = ADDR_WIDTH + INST_WIDTH;
    localparam logic [CW-1:0]         MAX_C   = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]           DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(PC_STEP);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         stale;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic [EW-1:0]         fifo_head;

    redirect_src_e         redirect_src;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] target;
    logic [CW:0]           in_use;
    logic                  issue;
    logic                  resp;
    logic                  push;
    logic                  pop;

    // NOTE: every signal driven here gets a default first so no path through
    // the block leaves it unassigned and infers a latch.
    always_comb begin
        redirect_src = pick_redirect(rob_if_en_in, decoder_if_en_in, bp_if_en_in);
        redirect     = (redirect_src != SRC_NONE) && rdy_in;
        target       = bp_if_pc_in;
        case (redirect_src)
            SRC_ROB:     target = rob_if_pc_in;
            SRC_DECODER: target = decoder_if_pc_in;
            default:     target = bp_if_pc_in;
        endcase
    end

    // Credit: FIFO entries plus live (non-stale) requests in flight must leave
    // room for one more response, so the FIFO can never overflow.
    assign in_use = {1'b0, fifo_count} + {1'b0, outstanding} - {1'b0, stale};

    assign if_icache_req_valid_out = !rst_in && !redirect
                                     && (outstanding < MAX_C)
                                     && (in_use < DEPTH_C);
    assign if_icache_addr_out      = pc;

    assign issue = if_icache_req_valid_out && icache_if_req_ready_in && rdy_in;
    assign resp  = icache_if_resp_valid_in && rdy_in;
    // Responses during a redirect, or owed to an abandoned path, are dropped.
    assign push  = resp && !redirect && (stale == '0);

    assign if_instqueue_valid_out = !rst_in && !fifo_empty && !redirect;
    assign pop                    = if_instqueue_valid_out && instqueue_if_ready_in && rdy_in;
    assign if_instqueue_pc_out    = fifo_head[EW-1:INST_WIDTH];
    assign if_instqueue_inst_out  = fifo_head[INST_WIDTH-1:0];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            stale       <= '0;
        end else if (rdy_in) begin
            outstanding <= outstanding + CW'(issue) - CW'(resp);
            if (redirect) begin
                pc      <= target;
                resp_pc <= target;
                // Everything still in flight after this edge belongs to the old path.
                stale   <= outstanding - CW'(resp);
            end else begin
                if (issue) pc <= pc + STEP;
                if (resp) begin
                    if (stale != '0) stale   <= stale - 1'b1;
                    else             resp_pc <= resp_pc + STEP;
                end
            end
        end
    end

    if_fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .flush     (redirect),
        .push      (push),
        .push_data ({resp_pc, icache_if_inst_in}),
        .pop       (pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
